regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_sb_decoder_5to32.sv | 22 ++
 rtl/regfile_sb.sv | 121 ++++++++++++
 tb/tb_regfile_sb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and types for the regfile_sb register file.
// Holds the default word width, register count, address width, the
// hardwired-zero register index and the word type.
package regfile_pkg;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef logic [WIDTH-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/regfile_sb_decoder_5to32.sv
// decoder_5to32: address to one-hot decoder with enable. With the enable
// low every output line is 0. Used for the write, both read and the
// busy-set paths of regfile_sb.
module decoder_5to32
  import regfile_pkg::*;
#(
  parameter int P_ADDR_W = ADDR_W,
  parameter int P_DEPTH  = DEPTH
) (
  input  logic [P_ADDR_W-1:0] i_addr,
  input  logic                i_en,
  output logic [P_DEPTH-1:0]  o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < P_DEPTH; gi++) begin : g_line
      assign o_onehot[gi] = i_en && (i_addr == P_ADDR_W'(gi));
    end
  endgenerate

endmodule : decoder_5to32

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 1-write register file with a pending-write
// scoreboard. Register 0 reads as zero and is never busy. A busy bit is
// set by ctrl_busySet and cleared by a write to the same register; if both
// hit one register in the same cycle the set wins.
// Optional feature: define REGFILE_BYPASS_EN to forward the write port to
// the read ports in the same cycle (inactive while ctrl_reset is high).
module regfile_sb
  import regfile_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  input  logic              ctrl_busySet,
  input  logic [ADDR_W-1:0] ctrl_busyReg,
  output logic              busy_A,
  output logic              busy_B
);

  logic [DEPTH-1:0] w_wr_dec;
  logic [DEPTH-1:0] w_set_dec;
  logic [DEPTH-1:0] w_rda_dec;
  logic [DEPTH-1:0] w_rdb_dec;

  word_t            w_words [DEPTH];
  logic [DEPTH-1:0] w_busy;

  word_t            w_rd_a;
  word_t            w_rd_b;
  logic             w_busy_a;
  logic             w_busy_b;

  // Register 0 has no storage, so its write and set lines go nowhere.
  logic             w_unused;
  assign w_unused = w_wr_dec[0] ^ w_set_dec[0];

  decoder_5to32 u_dec_wr  (.i_addr(ctrl_writeReg), .i_en(ctrl_writeEnable), .o_onehot(w_wr_dec));
  decoder_5to32 u_dec_set (.i_addr(ctrl_busyReg),  .i_en(ctrl_busySet),     .o_onehot(w_set_dec));
  decoder_5to32 u_dec_rda (.i_addr(ctrl_readRegA), .i_en(1'b1),             .o_onehot(w_rda_dec));
  decoder_5to32 u_dec_rdb (.i_addr(ctrl_readRegB), .i_en(1'b1),             .o_onehot(w_rdb_dec));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_words[gi] = '0;
        assign w_busy[gi]  = 1'b0;
      end else begin : g_word
        word_t r_word;
        logic  r_busy;

        // Data word: reset clears, otherwise load on its write decode line.
        always_ff @(posedge clock) begin
          if (ctrl_reset) begin
            r_word <= '0;
          end else if (w_wr_dec[gi]) begin
            r_word <= data_writeReg;
          end
        end

        // Busy bit: set has priority over the clear from writeback.
        always_ff @(posedge clock) begin
          if (ctrl_reset) begin
            r_busy <= 1'b0;
          end else if (w_set_dec[gi]) begin
            r_busy <= 1'b1;
          end else if (w_wr_dec[gi]) begin
            r_busy <= 1'b0;
          end
        end

        assign w_words[gi] = r_word;
        assign w_busy[gi]  = r_busy;
      end
    end
  endgenerate

  // One-hot AND-OR read muxes for both ports.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rda_dec[i]) w_rd_a = w_rd_a | w_words[i];
      if (w_rdb_dec[i]) w_rd_b = w_rd_b | w_words[i];
    end
  end

  assign w_busy_a = |(w_rda_dec & w_busy);
  assign w_busy_b = |(w_rdb_dec & w_busy);

`ifdef REGFILE_BYPASS_EN
  logic w_byp_a;
  logic w_byp_b;
  logic w_set_a;
  logic w_set_b;

  assign w_byp_a = ctrl_writeEnable && !ctrl_reset && (ctrl_writeReg != ZERO_REG)
                   && (ctrl_readRegA == ctrl_writeReg);
  assign w_byp_b = ctrl_writeEnable && !ctrl_reset && (ctrl_writeReg != ZERO_REG)
                   && (ctrl_readRegB == ctrl_writeReg);
  // A forwarded register is only busy if a new op claims it this cycle.
  assign w_set_a = ctrl_busySet && (ctrl_busyReg == ctrl_readRegA);
  assign w_set_b = ctrl_busySet && (ctrl_busyReg == ctrl_readRegB);

  assign data_readRegA = w_byp_a ? data_writeReg : w_rd_a;
  assign data_readRegB = w_byp_b ? data_writeReg : w_rd_b;
  assign busy_A        = w_byp_a ? w_set_a : w_busy_a;
  assign busy_B        = w_byp_b ? w_set_b : w_busy_b;
`else
  assign data_readRegA = w_rd_a;
  assign data_readRegB = w_rd_b;
  assign busy_A        = w_busy_a;
  assign busy_B        = w_busy_b;
`endif

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb.
// Expected values are hand-derived; the same-cycle read checks follow
// REGFILE_BYPASS_EN so the bench works in both builds.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic              clock;
  logic              ctrl_reset;
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  word_t             data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  word_t             data_readRegA;
  word_t             data_readRegB;
  logic              ctrl_busySet;
  logic [ADDR_W-1:0] ctrl_busyReg;
  logic              busy_A;
  logic              busy_B;

  int total = 0;
  int bad   = 0;

  regfile_sb dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .ctrl_busySet     (ctrl_busySet),
    .ctrl_busyReg     (ctrl_busyReg),
    .busy_A           (busy_A),
    .busy_B           (busy_B)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = %08h", tag, obs);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ctrl_reset       = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_busySet     = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_same_data;
    logic [31:0] exp_same_busy;

    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    ctrl_busySet     = 1'b0;
    ctrl_busyReg     = '0;
    tick();
    idle();

    // Reset state: every register reads 0 and is not busy.
    for (int i = 0; i < DEPTH; i++) begin
      ctrl_readRegA = ADDR_W'(i);
      ctrl_readRegB = ADDR_W'(DEPTH - 1 - i);
      #1;
      check($sformatf("rst_dA%0d", i), data_readRegA, 32'h0);
      check($sformatf("rst_dB%0d", i), data_readRegB, 32'h0);
      check($sformatf("rst_bA%0d", i), {31'b0, busy_A}, 32'h0);
      check($sformatf("rst_bB%0d", i), {31'b0, busy_B}, 32'h0);
    end

    // Write r5, read on both ports next cycle.
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5; data_writeReg = 32'hDEADBEEF;
    tick(); idle();
    ctrl_readRegA = 5; ctrl_readRegB = 5; #1;
    check("r5_A", data_readRegA, 32'hDEADBEEF);
    check("r5_B", data_readRegB, 32'hDEADBEEF);

    // Write to r0 is ignored.
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 0; data_writeReg = 32'h12345678;
    tick(); idle();
    ctrl_readRegA = 0; #1;
    check("r0_data", data_readRegA, 32'h0);

    // busySet r7, then writeback clears it.
    ctrl_busySet = 1'b1; ctrl_busyReg = 7;
    tick(); idle();
    ctrl_readRegA = 7; #1;
    check("r7_busy_set", {31'b0, busy_A}, 32'h1);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 7; data_writeReg = 32'hA5A5A5A5;
    tick(); idle(); #1;
    check("r7_busy_clr", {31'b0, busy_A}, 32'h0);
    check("r7_data", data_readRegA, 32'hA5A5A5A5);

    // Set and clear of r9 in one cycle: set wins.
    ctrl_busySet = 1'b1; ctrl_busyReg = 9;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 9; data_writeReg = 32'h1;
    tick(); idle();
    ctrl_readRegA = 9; #1;
    check("r9_busy", {31'b0, busy_A}, 32'h1);
    check("r9_data", data_readRegA, 32'h1);

    // busySet on r0 has no effect.
    ctrl_busySet = 1'b1; ctrl_busyReg = 0;
    tick(); idle();
    ctrl_readRegB = 0; #1;
    check("r0_busy", {31'b0, busy_B}, 32'h0);

    // Set r10 while clearing r9: both take effect.
    ctrl_busySet = 1'b1; ctrl_busyReg = 10;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 9; data_writeReg = 32'h2;
    tick(); idle();
    ctrl_readRegA = 9; ctrl_readRegB = 10; #1;
    check("r9_busy_clr", {31'b0, busy_A}, 32'h0);
    check("r9_data2", data_readRegA, 32'h2);
    check("r10_busy", {31'b0, busy_B}, 32'h1);

    // Same-cycle read of a register being written (r3, marked busy first).
    ctrl_busySet = 1'b1; ctrl_busyReg = 3;
    tick(); idle();
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 3; data_writeReg = 32'hCAFEF00D;
    ctrl_readRegA = 3; ctrl_readRegB = 3; #1;
`ifdef REGFILE_BYPASS_EN
    exp_same_data = 32'hCAFEF00D;
    exp_same_busy = 32'h0;
`else
    exp_same_data = 32'h0;
    exp_same_busy = 32'h1;
`endif
    check("r3_same_data", data_readRegA, exp_same_data);
    check("r3_same_busy", {31'b0, busy_B}, exp_same_busy);
    tick(); idle(); #1;
    check("r3_next_data", data_readRegB, 32'hCAFEF00D);
    check("r3_next_busy", {31'b0, busy_A}, 32'h0);

    // Fill r1..r31 with their index and mark each busy (set wins over clear).
    for (int i = 1; i < DEPTH; i++) begin
      ctrl_writeEnable = 1'b1; ctrl_writeReg = ADDR_W'(i); data_writeReg = 32'(i);
      ctrl_busySet = 1'b1; ctrl_busyReg = ADDR_W'(i);
      tick();
    end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      ctrl_readRegA = ADDR_W'(i);
      ctrl_readRegB = ADDR_W'(i);
      #1;
      check($sformatf("fill_d%0d", i), data_readRegA, 32'(i));
      check($sformatf("fill_b%0d", i), {31'b0, busy_B}, (i == 0) ? 32'h0 : 32'h1);
    end

    // Reset with a concurrent write to r4 and set on r6: reset wins,
    // including over same-cycle forwarding.
    ctrl_reset = 1'b1;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 4; data_writeReg = 32'h0000FFFF;
    ctrl_busySet = 1'b1; ctrl_busyReg = 6;
    ctrl_readRegA = 4; ctrl_readRegB = 4; #1;
    check("rst_nobyp_d", data_readRegA, 32'h4);
    check("rst_nobyp_b", {31'b0, busy_B}, 32'h1);
    tick(); idle();
    for (int i = 0; i < DEPTH; i++) begin
      ctrl_readRegA = ADDR_W'(i);
      ctrl_readRegB = ADDR_W'(DEPTH - 1 - i);
      #1;
      check($sformatf("rst2_dA%0d", i), data_readRegA, 32'h0);
      check($sformatf("rst2_dB%0d", i), data_readRegB, 32'h0);
      check($sformatf("rst2_bA%0d", i), {31'b0, busy_A}, 32'h0);
      check($sformatf("rst2_bB%0d", i), {31'b0, busy_B}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_sb
